fp_mant_mult_seq: RTL and testbench

- Sequential shift-and-add mantissa multiplier for the small floating-point multiplier datapath.
- Sits directly upstream of the exponent generator (Ze_generate): it produces the normalisation flag s that selects bias-7 vs bias-6 exponent subtraction, plus the normalised, truncated product mantissa and product sign.
- Start/busy/done handshake; one multiply in flight at a time.

---
 rtl/fp_mant_mult_seq_pkg.sv | 16 +
 rtl/fp_mant_mult_seq.sv | 109 ++++++++++
 tb/tb_fp_mant_mult_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fp_mant_mult_seq_pkg.sv
// Shared types and constants for the sequential mantissa multiplier and exponent stage.
// MW_DEF is the stored mantissa width; BIAS is shared with the exponent generator.
package fp_mant_mult_seq_pkg;

  localparam int MW_DEF  = 3;
  localparam int OPW_DEF = MW_DEF + 1;
  localparam int PW_DEF  = 2 * MW_DEF + 2;
  localparam int BIAS    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mant_mult_seq.sv
// Shift-and-add mantissa multiply with normalise/truncate; start-to-done is MW+2 edges, fixed.
// One multiply in flight: start is ignored while busy and nothing is queued.
module fp_mant_mult_seq
  import fp_mant_mult_seq_pkg::*;
#(
  parameter int MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          xs,
  input  logic          ys,
  input  logic [MW-1:0] xm,
  input  logic [MW-1:0] ym,
  input  logic          xz,
  input  logic          yz,
  output logic          busy,
  output logic          done,
  output logic          zs,
  output logic [MW-1:0] zm,
  output logic          s,
  output logic          sticky,
  output logic          zz
);

  localparam int OPW = MW + 1;
  localparam int PW  = 2 * MW + 2;
  localparam int CW  = (MW < 1) ? 1 : $clog2(MW + 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   a, p;
  logic [OPW-1:0]  b;
  logic [CW-1:0]   cnt;
  logic            zs_i, zz_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (cnt == CW'(MW)) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      p      <= '0;
      cnt    <= '0;
      zs_i   <= 1'b0;
      zz_i   <= 1'b0;
      done   <= 1'b0;
      zs     <= 1'b0;
      zm     <= '0;
      s      <= 1'b0;
      sticky <= 1'b0;
      zz     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a    <= PW'({1'b1, xm});
            b    <= {1'b1, ym};
            p    <= '0;
            cnt  <= '0;
            zs_i <= xs ^ ys;
            zz_i <= xz | yz;
          end
        end
        MUL: begin
          p   <= p + (b[0] ? a : '0);
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          done <= 1'b1;
          zs   <= zs_i;
          // Product of two [1,2) values is in [1,4): only the top bit decides normalisation.
          if (zz_i) begin
            zm     <= '0;
            s      <= 1'b0;
            sticky <= 1'b0;
            zz     <= 1'b1;
          end else if (p[PW-1]) begin
            zm     <= p[PW-2 -: MW];
            s      <= 1'b1;
            sticky <= |p[MW:0];
            zz     <= 1'b0;
          end else begin
            zm     <= p[PW-3 -: MW];
            s      <= 1'b0;
            sticky <= |p[MW-1:0];
            zz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_mult_seq.sv
// Directed and randomised checks of fp_mant_mult_seq against hand-computed values and a product model.
module tb_fp_mant_mult_seq;

  logic       clk = 1'b0;
  logic       rst, start, xs, ys, xz, yz;
  logic [2:0] xm, ym;
  logic       busy, done, zs, s, sticky, zz;
  logic [2:0] zm;
  logic [6:0] res;
  int         errs = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         lat, snap;

  fp_mant_mult_seq #(.MW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .xs(xs), .ys(ys), .xm(xm), .ym(ym),
    .xz(xz), .yz(yz), .busy(busy), .done(done), .zs(zs), .zm(zm), .s(s),
    .sticky(sticky), .zz(zz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) done_cnt++;
  assign res = {zs, zz, s, sticky, zm};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] a, input logic [2:0] b,
                          input logic sx, input logic sy, input logic zx, input logic zy);
    xm = a; ym = b; xs = sx; ys = sy; xz = zx; yz = zy;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(output int n_out);
    n_out = -1;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (done === 1'b1) begin
        n_out = n;
        break;
      end
    end
  endtask

  // {zs, zz, s, sticky, zm} from arithmetic on the full product
  function automatic logic [6:0] model(input logic [2:0] a, input logic [2:0] b,
                                       input logic sx, input logic sy, input logic zx, input logic zy);
    int         p;
    logic [2:0] m;
    logic       sn, st;
    p = (8 + int'(a)) * (8 + int'(b));
    if (zx | zy) return {sx ^ sy, 1'b1, 1'b0, 1'b0, 3'b000};
    if (p >= 128) begin
      m = 3'((p / 16) % 8); st = (p % 16) != 0; sn = 1'b1;
    end else begin
      m = 3'((p / 8) % 8);  st = (p % 8) != 0;  sn = 1'b0;
    end
    return {sx ^ sy, 1'b0, sn, st, m};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; xs = 0; ys = 0; xz = 0; yz = 0; xm = 0; ym = 0;
    tick; tick;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outs", 32'(res), 32'd0);

    // start while reset held must be ignored
    start = 1'b1; tick; tick; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);
    rst = 1'b0; tick;
    chk("idle_busy", 32'(busy), 32'd0);

    // 8*8=64: unnormalised, exact, negative sign
    start_op(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("op1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("op1_lat", 32'(lat), 32'd5);
    chk("op1_res", 32'(res), 32'b1000000);
    tick;
    chk("op1_done_pulse", 32'(done), 32'd0);
    chk("op1_hold", 32'(res), 32'b1000000);
    chk("op1_idle", 32'(busy), 32'd0);

    // 12*12=144: normalised, exact
    start_op(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    chk("op2_lat", 32'(lat), 32'd5);
    chk("op2_res", 32'(res), 32'b0010001);

    // 15*15=225: normalised, inexact
    start_op(3'b111, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(lat);
    chk("op3_lat", 32'(lat), 32'd5);
    chk("op3_res", 32'(res), 32'b0011110);

    // 10*9=90: unnormalised, inexact; then back-to-back zero operand on the done cycle
    start_op(3'b010, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    chk("op4_lat", 32'(lat), 32'd5);
    chk("op4_res", 32'(res), 32'b0001011);
    start_op(3'b101, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", 32'(res), 32'b0001011);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd5);
    chk("b2b_res", 32'(res), 32'b0100000);

    // start while busy is ignored; only the first operands count
    start_op(3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    start_op(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    snap = done_cnt;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd3);
    chk("ign_res", 32'(res), 32'b1011110);
    for (int i = 0; i < 8; i++) tick;
    chk("ign_no_2nd_done", 32'(done_cnt - snap), 32'd1);

    // reset two cycles after start discards the operation
    start_op(3'b011, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", 32'(res), 32'd0);
    snap = done_cnt;
    for (int i = 0; i < 10; i++) tick;
    chk("midrst_no_done", 32'(done_cnt - snap), 32'd0);

    // random operands against the model
    snap = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] ra, rb;
      logic       rsx, rsy, rzx, rzy;
      ra  = 3'($urandom_range(0, 7));
      rb  = 3'($urandom_range(0, 7));
      rsx = 1'($urandom_range(0, 1));
      rsy = 1'($urandom_range(0, 1));
      rzx = ($urandom_range(0, 15) == 0);
      rzy = ($urandom_range(0, 15) == 0);
      start_op(ra, rb, rsx, rsy, rzx, rzy);
      wait_done(lat);
      chk("rnd_lat", 32'(lat), 32'd5);
      chk("rnd_res", 32'(res), 32'(model(ra, rb, rsx, rsy, rzx, rzy)));
    end
    tick;
    chk("rnd_done_count", 32'(done_cnt - snap), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
